instruction_fetch: RTL

//  Fetch stage of the pipelined MIPS core; sits directly upstream of program_memory.

---
 rtl/instruction_fetch_pkg.sv | 18 +
 rtl/instruction_fetch_if.sv | 11 +
 rtl/instruction_fetch_program_counter.sv | 45 ++++
 rtl/instruction_fetch.sv | 89 ++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared encodings and default widths for the fetch stage of the pipelined MIPS core.
// Imported by the program counter, the fetch top level and the memory-bus interface users.
package instruction_fetch_pkg;

   localparam int NB_ADDR_DEF        = 10;
   localparam int NB_INSTRUCTION_DEF = 32;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_SRC_SEQ    = 2'b00,
      PC_SRC_BRANCH = 2'b01,
      PC_SRC_JUMP   = 2'b10,
      PC_SRC_JR     = 2'b11
   } pc_src_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus to program_memory: word address out, combinationally read instruction back.
interface instruction_fetch_if #(
   parameter int NB_ADDR        = 10,
   parameter int NB_INSTRUCTION = 32
);
   logic [NB_ADDR-1:0]        read_addr;
   logic [NB_INSTRUCTION-1:0] instruction;

   modport master (output read_addr, input instruction);
   modport slave  (input read_addr, output instruction);
endinterface

// File: rtl/instruction_fetch_program_counter.sv
// PC register with wrapping incrementer, 4:1 next-PC select and hold control.
// A redirect always wins over hold; a frozen stage (enable low) keeps the PC untouched.
module instruction_fetch_program_counter
   import instruction_fetch_pkg::*;
#(
   parameter int NB_ADDR = NB_ADDR_DEF
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_hold,
   input  pc_src_e            i_pc_src,
   input  logic [NB_ADDR-1:0] i_branch_target,
   input  logic [NB_ADDR-1:0] i_jump_target,
   input  logic [NB_ADDR-1:0] i_jr_target,
   output logic [NB_ADDR-1:0] o_pc,
   output logic [NB_ADDR-1:0] o_pc_plus1
);

   logic [NB_ADDR-1:0] pc_q;
   logic [NB_ADDR-1:0] pc_d;

   assign o_pc       = pc_q;
   assign o_pc_plus1 = pc_q + NB_ADDR'(1);

   // NOTE: pc_d gets a default before any branch so this block can never infer a latch.
   always_comb begin
      pc_d = pc_q;
      if (i_enable) begin
         unique case (i_pc_src)
            PC_SRC_BRANCH: pc_d = i_branch_target;
            PC_SRC_JUMP:   pc_d = i_jump_target;
            PC_SRC_JR:     pc_d = i_jr_target;
            default:       pc_d = i_hold ? pc_q : o_pc_plus1;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) pc_q <= '0;
      else         pc_q <= pc_d;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives program_memory, captures the IF/ID register and stops on the HALT word.
// Per edge priority: reset > !enable > redirect/flush > halted > stall > normal fetch.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int NB_ADDR        = NB_ADDR_DEF,
   parameter int NB_INSTRUCTION = NB_INSTRUCTION_DEF
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_stall,
   input  logic                      i_flush,
   input  logic [1:0]                i_pc_src,
   input  logic [NB_ADDR-1:0]        i_branch_target,
   input  logic [NB_ADDR-1:0]        i_jump_target,
   input  logic [NB_ADDR-1:0]        i_jr_target,
   instruction_fetch_if.master       mem_bus,
   output logic [NB_INSTRUCTION-1:0] o_if_id_instruction,
   output logic [NB_ADDR-1:0]        o_if_id_pc_next,
   output logic                      o_if_id_valid,
   output logic                      o_halt
);

   localparam logic [NB_INSTRUCTION-1:0] HALT_INSN = NB_INSTRUCTION'(HALT_WORD);
   localparam logic [NB_INSTRUCTION-1:0] NOP_INSN  = NB_INSTRUCTION'(NOP_WORD);

   typedef struct packed {
      logic [NB_INSTRUCTION-1:0] instruction;
      logic [NB_ADDR-1:0]        pc_next;
      logic                      valid;
   } if_id_t;

   if_id_t             if_id_q, if_id_d;
   logic               halt_q, halt_d;
   logic [NB_ADDR-1:0] pc, pc_plus1;
   logic               is_halt;
   logic               pc_hold;

   assign is_halt = (mem_bus.instruction == HALT_INSN);
   // A flush edge advances sequentially even when halted or stalled, and never detects HALT.
   assign pc_hold = !i_flush && (halt_q || i_stall || is_halt);

   instruction_fetch_program_counter #(.NB_ADDR(NB_ADDR)) u_program_counter (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_enable        (i_enable),
      .i_hold          (pc_hold),
      .i_pc_src        (pc_src_e'(i_pc_src)),
      .i_branch_target (i_branch_target),
      .i_jump_target   (i_jump_target),
      .i_jr_target     (i_jr_target),
      .o_pc            (pc),
      .o_pc_plus1      (pc_plus1)
   );

   always_comb begin
      if_id_d = if_id_q;
      halt_d  = halt_q;
      if (i_enable) begin
         if (i_flush || halt_q) begin
            if_id_d.instruction = NOP_INSN;
            if_id_d.valid       = 1'b0;
         end else if (!i_stall) begin
            if_id_d.instruction = mem_bus.instruction;
            if_id_d.pc_next     = pc_plus1;
            if_id_d.valid       = 1'b1;
            halt_d              = is_halt;
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         if_id_q <= '{instruction: NOP_INSN, pc_next: '0, valid: 1'b0};
         halt_q  <= 1'b0;
      end else begin
         if_id_q <= if_id_d;
         halt_q  <= halt_d;
      end
   end

   assign mem_bus.read_addr   = pc;
   assign o_if_id_instruction = if_id_q.instruction;
   assign o_if_id_pc_next     = if_id_q.pc_next;
   assign o_if_id_valid       = if_id_q.valid;
   assign o_halt              = halt_q;

endmodule
